// File: rtl/usb_tx_sched.sv
// USB transmit scheduler: arbitrates handshake and data packet requests (handshake
// has strict priority), issues one packet command, tracks the transmitter, then holds a gap.
module usb_tx_sched #(
    parameter int START_TIMEOUT = 64,
    parameter int IPG_CYCLES    = 16,
    parameter int MIN_OCC       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [1:0] hs_pid,
    input  logic       data_req,
    input  logic       data_pid,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic [2:0] tx_packet,
    output logic       hs_gnt,
    output logic       data_gnt,
    output logic       hs_done,
    output logic       data_done,
    output logic       sched_error,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_ACTIVE     = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST   = 16'(IPG_CYCLES - 1);
    localparam logic [6:0]  OCC_MIN    = 7'(MIN_OCC);

    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  code_q, code_d;
    logic        owner_hs_q, owner_hs_d;
    logic        fail_q, fail_d;
    logic [2:0]  tx_packet_q, tx_packet_d;
    logic        hs_gnt_q, hs_gnt_d;
    logic        data_gnt_q, data_gnt_d;
    logic        hs_done_q, hs_done_d;
    logic        data_done_q, data_done_d;
    logic        sched_error_q, sched_error_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d       = state_q;
        timer_d       = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        code_d        = code_q;
        owner_hs_d    = owner_hs_q;
        fail_d        = fail_q;
        tx_packet_d   = 3'd0;
        hs_gnt_d      = 1'b0;
        data_gnt_d    = 1'b0;
        hs_done_d     = 1'b0;
        data_done_d   = 1'b0;
        sched_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_req) begin
                    hs_gnt_d   = 1'b1;
                    owner_hs_d = 1'b1;
                    fail_d     = 1'b0;
                    // Code 0 marks the reserved PID so ISSUE can reject it.
                    case (hs_pid)
                        2'b00:   code_d = 3'd3;
                        2'b01:   code_d = 3'd4;
                        2'b10:   code_d = 3'd5;
                        default: code_d = 3'd0;
                    endcase
                    state_d = ST_ISSUE;
                end else if (data_req && (buffer_occupancy >= OCC_MIN)) begin
                    data_gnt_d = 1'b1;
                    owner_hs_d = 1'b0;
                    fail_d     = 1'b0;
                    code_d     = data_pid ? 3'd2 : 3'd1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (code_q == 3'd0) begin
                    sched_error_d = 1'b1;
                    state_d       = ST_GAP;
                end else begin
                    tx_packet_d = code_q;
                    state_d     = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (tx_transfer_active) begin
                    state_d = ST_ACTIVE;
                end else if (timer_q >= START_LAST) begin
                    sched_error_d = 1'b1;
                    state_d       = ST_GAP;
                end
            end
            ST_ACTIVE: begin
                if (tx_error) fail_d = 1'b1;
                if (!tx_transfer_active) begin
                    if (fail_q || tx_error) sched_error_d = 1'b1;
                    else if (owner_hs_q)    hs_done_d     = 1'b1;
                    else                    data_done_d   = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_q >= GAP_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) timer_d = 16'd0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= 16'd0;
            code_q        <= 3'd0;
            owner_hs_q    <= 1'b0;
            fail_q        <= 1'b0;
            tx_packet_q   <= 3'd0;
            hs_gnt_q      <= 1'b0;
            data_gnt_q    <= 1'b0;
            hs_done_q     <= 1'b0;
            data_done_q   <= 1'b0;
            sched_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            code_q        <= code_d;
            owner_hs_q    <= owner_hs_d;
            fail_q        <= fail_d;
            tx_packet_q   <= tx_packet_d;
            hs_gnt_q      <= hs_gnt_d;
            data_gnt_q    <= data_gnt_d;
            hs_done_q     <= hs_done_d;
            data_done_q   <= data_done_d;
            sched_error_q <= sched_error_d;
            busy_q        <= busy_d;
        end
    end

    assign tx_packet   = tx_packet_q;
    assign hs_gnt      = hs_gnt_q;
    assign data_gnt    = data_gnt_q;
    assign hs_done     = hs_done_q;
    assign data_done   = data_done_q;
    assign sched_error = sched_error_q;
    assign busy        = busy_q;

endmodule
